// File: rtl/alu_issue_sequencer_pkg.sv
// Shared opcode, state and flag-bit constants for the ALU issue sequencer.
package alu_issue_sequencer_pkg;

    localparam int OPC_W = 5;
    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'd0;
    localparam opcode_t OP_ADD  = 5'd1;
    localparam opcode_t OP_SUB  = 5'd2;
    localparam opcode_t OP_MUL  = 5'd3;
    localparam opcode_t OP_DIV  = 5'd4;
    localparam opcode_t OP_NOT  = 5'd5;
    localparam opcode_t OP_AND  = 5'd6;
    localparam opcode_t OP_OR   = 5'd7;
    localparam opcode_t OP_XOR  = 5'd8;
    localparam opcode_t OP_INC  = 5'd9;
    localparam opcode_t OP_CMP  = 5'd10;
    localparam opcode_t OP_RR   = 5'd11;
    localparam opcode_t OP_RL   = 5'd12;
    localparam opcode_t OP_SETB = 5'd13;
    localparam opcode_t OP_CLRB = 5'd14;
    localparam opcode_t OP_CPLB = 5'd15;
    localparam opcode_t OP_SETF = 5'd16;
    localparam opcode_t OP_CLRF = 5'd17;
    localparam opcode_t OP_CPLF = 5'd18;
    localparam opcode_t OP_MOVB = 5'd19;
    localparam opcode_t OP_LBL  = 5'd20;
    localparam opcode_t OP_LBH  = 5'd21;
    localparam opcode_t OP_MOV  = 5'd22;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WB_HI = 2'd2;

    localparam int FLAG_C   = 0;
    localparam int FLAG_V   = 1;
    localparam int FLAG_CMP = 2;
    localparam int FLAG_EQ  = 3;
    localparam int FLAG_IO  = 4;
    localparam int FLAG_P   = 5;
    localparam int FLAG_N   = 6;
    localparam int FLAG_Z   = 7;

endpackage

// File: rtl/alu_issue_sequencer_alu_op_classifier.sv
// Decodes a captured opcode into ALU-class, register-write and dual-write attributes.
module alu_op_classifier
    import alu_issue_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic             op2_is_zero,
    output logic             is_alu,
    output logic             writes_rd,
    output logic             dual_write
);

    always_comb begin
        is_alu     = 1'b0;
        writes_rd  = 1'b0;
        dual_write = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOT, OP_AND, OP_OR, OP_XOR,
            OP_INC, OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB: begin
                is_alu    = 1'b1;
                writes_rd = 1'b1;
            end
            OP_CMP, OP_SETF, OP_CLRF, OP_CPLF, OP_MOVB: begin
                is_alu = 1'b1;
            end
            OP_LBL, OP_LBH, OP_MOV: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
        // A zero divisor leaves only the saturated quotient to write.
        dual_write = (opcode == OP_MUL) || ((opcode == OP_DIV) && !op2_is_zero);
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue stage between decode and the combinational ALU: captures operands,
// owns the flag register and sequences one or two register-file writes.
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_opcode,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic [DATA_W-1:0] issue_rs1_data,
    input  logic [DATA_W-1:0] issue_rs2_data,
    input  logic [7:0]        issue_imm,
    input  logic [3:0]        issue_bitpos,
    input  logic              issue_bit_in,
    output logic              alu_en,
    output logic [4:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [7:0]        alu_imm,
    output logic [3:0]        alu_bitpos,
    output logic              alu_bit_in,
    output logic [REG_AW-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_result_0,
    input  logic [DATA_W-1:0] alu_result_1,
    input  logic [DATA_W-1:0] alu_next_flags,
    output logic [DATA_W-1:0] current_flags,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    logic [1:0]        state_reg, state_next;
    logic [4:0]        opcode_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [DATA_W-1:0] op1_reg, op2_reg, hi_q_reg, flags_reg;
    logic [7:0]        imm_reg;
    logic [3:0]        bitpos_reg;
    logic              bit_in_reg;

    logic is_alu, writes_rd, dual_write;
    logic in_exec, in_wb_hi, capture;

    logic [REG_AW-1:0] src_addr [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] src_fwd  [2];

    alu_op_classifier u_classifier (
        .opcode      (opcode_reg),
        .op2_is_zero (op2_reg == '0),
        .is_alu      (is_alu),
        .writes_rd   (writes_rd),
        .dual_write  (dual_write)
    );

    assign in_exec  = (state_reg == ST_EXEC);
    assign in_wb_hi = (state_reg == ST_WB_HI);

    assign issue_ready = !(in_exec && dual_write);
    assign capture     = issue_valid && issue_ready;
    assign busy        = (state_reg != ST_IDLE);

    assign wb_en   = (in_exec && writes_rd) || in_wb_hi;
    assign wb_addr = in_wb_hi ? rd_reg + REG_AW'(1) : rd_reg;
    assign wb_data = in_wb_hi ? hi_q_reg : alu_result_0;

    assign alu_en        = in_exec && is_alu;
    assign alu_opcode    = opcode_reg;
    assign alu_op1       = op1_reg;
    assign alu_op2       = op2_reg;
    assign alu_imm       = imm_reg;
    assign alu_bitpos    = bitpos_reg;
    assign alu_bit_in    = bit_in_reg;
    assign alu_rd        = rd_reg;
    assign current_flags = flags_reg;

    assign src_addr[0] = issue_rs1;
    assign src_addr[1] = issue_rs2;
    assign src_data[0] = issue_rs1_data;
    assign src_data[1] = issue_rs2_data;

    // The register file has not yet absorbed the write in flight, so bypass it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign src_fwd[gi] = (wb_en && (src_addr[gi] == wb_addr)) ? wb_data : src_data[gi];
        end
    endgenerate

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = capture ? ST_EXEC : ST_IDLE;
            ST_EXEC:  state_next = dual_write ? ST_WB_HI : (capture ? ST_EXEC : ST_IDLE);
            ST_WB_HI: state_next = capture ? ST_EXEC : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= '0;
            rd_reg     <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            imm_reg    <= '0;
            bitpos_reg <= '0;
            bit_in_reg <= 1'b0;
            hi_q_reg   <= '0;
            flags_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (in_exec && is_alu) begin
                flags_reg <= alu_next_flags;
            end
            if (in_exec && dual_write) begin
                hi_q_reg <= alu_result_1;
            end
            if (capture) begin
                opcode_reg <= issue_opcode;
                rd_reg     <= issue_rd;
                op1_reg    <= src_fwd[0];
                op2_reg    <= src_fwd[1];
                imm_reg    <= issue_imm;
                bitpos_reg <= issue_bitpos;
                bit_in_reg <= issue_bit_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small behavioural ALU on its outputs.
module tb_alu_issue_sequencer;
    import alu_issue_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [4:0]  issue_opcode = '0;
    logic [2:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic [15:0] issue_rs1_data = '0, issue_rs2_data = '0;
    logic [7:0]  issue_imm = '0;
    logic [3:0]  issue_bitpos = '0;
    logic        issue_bit_in = 1'b0;
    logic        alu_en;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_op1, alu_op2;
    logic [7:0]  alu_imm;
    logic [3:0]  alu_bitpos;
    logic        alu_bit_in;
    logic [2:0]  alu_rd;
    logic [15:0] alu_result_0, alu_result_1, alu_next_flags, current_flags;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_sequencer dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_imm(issue_imm), .issue_bitpos(issue_bitpos), .issue_bit_in(issue_bit_in),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_imm(alu_imm), .alu_bitpos(alu_bitpos), .alu_bit_in(alu_bit_in), .alu_rd(alu_rd),
        .alu_result_0(alu_result_0), .alu_result_1(alu_result_1),
        .alu_next_flags(alu_next_flags), .current_flags(current_flags),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    // Behavioural ALU; unknown opcodes return poison values so stray updates show up.
    logic [16:0] m_sum;
    logic [31:0] m_prod;
    always_comb begin
        alu_result_0   = 16'hBEEF;
        alu_result_1   = 16'h0000;
        alu_next_flags = 16'hDEAD;
        m_sum          = '0;
        m_prod         = '0;
        case (alu_opcode)
            OP_ADD: begin
                m_sum = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_result_0 = m_sum[15:0];
                alu_next_flags = current_flags;
                alu_next_flags[FLAG_C] = m_sum[16];
            end
            OP_SUB: begin
                m_sum = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_result_0 = m_sum[15:0];
                alu_next_flags = current_flags;
                alu_next_flags[FLAG_C] = m_sum[16];
            end
            OP_MUL: begin
                m_prod = 32'(alu_op1) * 32'(alu_op2);
                alu_result_0 = m_prod[15:0];
                alu_result_1 = m_prod[31:16];
                alu_next_flags = current_flags;
                alu_next_flags[FLAG_V] = (m_prod[31:16] != 16'h0);
            end
            OP_DIV: begin
                alu_next_flags = current_flags;
                if (alu_op2 == 16'h0) begin
                    alu_result_0 = 16'hFFFF;
                    alu_next_flags[FLAG_V] = 1'b1;
                end else begin
                    alu_result_0 = alu_op1 / alu_op2;
                    alu_result_1 = alu_op1 % alu_op2;
                    alu_next_flags[FLAG_V] = 1'b0;
                end
            end
            OP_AND: begin alu_result_0 = alu_op1 & alu_op2; alu_next_flags = current_flags; end
            OP_OR:  begin alu_result_0 = alu_op1 | alu_op2; alu_next_flags = current_flags; end
            OP_XOR: begin alu_result_0 = alu_op1 ^ alu_op2; alu_next_flags = current_flags; end
            OP_NOT: begin alu_result_0 = ~alu_op1;          alu_next_flags = current_flags; end
            OP_INC: begin alu_result_0 = alu_op1 + 16'h1;   alu_next_flags = current_flags; end
            OP_CMP: begin
                alu_result_0 = 16'h0;
                alu_next_flags = current_flags;
                alu_next_flags[FLAG_EQ]  = (alu_op1 == alu_op2);
                alu_next_flags[FLAG_Z]   = (alu_op1 == alu_op2);
                alu_next_flags[FLAG_CMP] = (alu_op1 < alu_op2);
            end
            OP_SETF: begin
                alu_result_0 = 16'h0;
                alu_next_flags = current_flags;
                alu_next_flags[alu_bitpos] = 1'b1;
            end
            OP_MOVB: begin
                alu_result_0 = 16'h0;
                alu_next_flags = current_flags;
                alu_next_flags[alu_bitpos] = alu_bit_in;
            end
            OP_LBL: alu_result_0 = {alu_op1[15:8], alu_imm};
            OP_LBH: alu_result_0 = {alu_imm, alu_op1[7:0]};
            OP_MOV: alu_result_0 = alu_op1;
            default: ;
        endcase
        if (alu_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC}) begin
            alu_next_flags[FLAG_Z] = (alu_result_0 == 16'h0);
            alu_next_flags[FLAG_N] = alu_result_0[15];
        end
    end

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] d1, d2;
        logic [7:0]  imm;
        logic [3:0]  bitpos;
        logic        exp_alu_en;
        logic        exp_wen;
        logic [15:0] exp_data;
        logic [15:0] exp_flags;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [7:0] imm, input logic [3:0] bitpos);
        issue_opcode   = op;
        issue_rd       = rd;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_rs1_data = d1;
        issue_rs2_data = d2;
        issue_imm      = imm;
        issue_bitpos   = bitpos;
        issue_bit_in   = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{OP_ADD,  3'd4, 3'd1, 3'd2, 16'h0003, 16'h0005, 8'h00, 4'd0, 1'b1, 1'b1, 16'h0008, 16'h0000};
        vecs[1] = '{OP_SUB,  3'd1, 3'd3, 3'd4, 16'h0005, 16'h0003, 8'h00, 4'd0, 1'b1, 1'b1, 16'h0002, 16'h0000};
        vecs[2] = '{OP_AND,  3'd3, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 8'h00, 4'd0, 1'b1, 1'b1, 16'h00F0, 16'h0000};
        vecs[3] = '{OP_XOR,  3'd5, 3'd1, 3'd2, 16'hFFFF, 16'h00FF, 8'h00, 4'd0, 1'b1, 1'b1, 16'hFF00, 16'h0040};
        vecs[4] = '{OP_MOV,  3'd6, 3'd1, 3'd0, 16'h1234, 16'h0000, 8'h00, 4'd0, 1'b0, 1'b1, 16'h1234, 16'h0040};
        vecs[5] = '{OP_CMP,  3'd0, 3'd1, 3'd2, 16'h0005, 16'h0005, 8'h00, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h00C8};
        vecs[6] = '{OP_SETF, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 8'h00, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h00D8};
        vecs[7] = '{OP_INC,  3'd0, 3'd1, 3'd0, 16'h00FF, 16'h0000, 8'h00, 4'd0, 1'b1, 1'b1, 16'h0100, 16'h0018};
        vecs[8] = '{OP_ADD,  3'd2, 3'd3, 3'd4, 16'hFFFF, 16'h0001, 8'h00, 4'd0, 1'b1, 1'b1, 16'h0000, 16'h0099};
        vecs[9] = '{5'd31,   3'd1, 3'd1, 3'd2, 16'h0007, 16'h0009, 8'h00, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0099};

        // Reset state
        step();
        step();
        chk("reset_wb_en", 32'(wb_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(issue_ready), 32'd1);
        chk("reset_flags", 32'(current_flags), 32'h0);
        reset = 1'b0;
        step();

        // Single instructions from IDLE
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2,
                  vecs[i].imm, vecs[i].bitpos);
            issue_valid = 1'b1;
            step();
            issue_valid = 1'b0;
            $display("vec %0d op=%0d wb_en=%0d addr=%0d data=%h", i, vecs[i].op, wb_en, wb_addr, wb_data);
            chk("vec_busy", 32'(busy), 32'd1);
            chk("vec_alu_en", 32'(alu_en), 32'(vecs[i].exp_alu_en));
            chk("vec_alu_rd", 32'(alu_rd), 32'(vecs[i].rd));
            chk("vec_wb_en", 32'(wb_en), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_wen) begin
                chk("vec_wb_addr", 32'(wb_addr), 32'(vecs[i].rd));
                chk("vec_wb_data", 32'(wb_data), 32'(vecs[i].exp_data));
            end
            step();
            chk("vec_flags", 32'(current_flags), 32'(vecs[i].exp_flags));
            chk("vec_idle", 32'(busy), 32'd0);
            chk("vec_idle_wb", 32'(wb_en), 32'd0);
        end

        // MUL with rd+1 wrapping to r0
        drive(OP_MUL, 3'd7, 3'd1, 3'd2, 16'h1234, 16'h0100, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        $display("mul lo: wb_en=%0d addr=%0d data=%h ready=%0d", wb_en, wb_addr, wb_data, issue_ready);
        chk("mul_lo_ready", 32'(issue_ready), 32'd0);
        chk("mul_lo_wb_en", 32'(wb_en), 32'd1);
        chk("mul_lo_addr", 32'(wb_addr), 32'd7);
        chk("mul_lo_data", 32'(wb_data), 32'h3400);
        step();
        $display("mul hi: wb_en=%0d addr=%0d data=%h ready=%0d", wb_en, wb_addr, wb_data, issue_ready);
        chk("mul_hi_wb_en", 32'(wb_en), 32'd1);
        chk("mul_hi_addr", 32'(wb_addr), 32'd0);
        chk("mul_hi_data", 32'(wb_data), 32'h0012);
        chk("mul_hi_ready", 32'(issue_ready), 32'd1);
        step();
        chk("mul_done_busy", 32'(busy), 32'd0);

        // LBH then LBL back-to-back, register file still stale
        drive(OP_LBH, 3'd2, 3'd2, 3'd0, 16'h0000, 16'h0000, 8'hAB, 4'd0);
        issue_valid = 1'b1;
        step();
        drive(OP_LBL, 3'd2, 3'd2, 3'd0, 16'h0000, 16'h0000, 8'hCD, 4'd0);
        $display("lbh: wb_en=%0d addr=%0d data=%h", wb_en, wb_addr, wb_data);
        chk("lbh_data", 32'(wb_data), 32'hAB00);
        chk("lbh_ready", 32'(issue_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        $display("lbl: wb_en=%0d addr=%0d data=%h", wb_en, wb_addr, wb_data);
        chk("lbl_wb_en", 32'(wb_en), 32'd1);
        chk("lbl_addr", 32'(wb_addr), 32'd2);
        chk("lbl_data", 32'(wb_data), 32'hABCD);
        step();

        // DIV by zero: one write, V set, no high-word cycle
        drive(OP_DIV, 3'd3, 3'd1, 3'd2, 16'h0010, 16'h0000, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        $display("div0: wb_en=%0d addr=%0d data=%h ready=%0d", wb_en, wb_addr, wb_data, issue_ready);
        chk("div0_addr", 32'(wb_addr), 32'd3);
        chk("div0_data", 32'(wb_data), 32'hFFFF);
        chk("div0_ready", 32'(issue_ready), 32'd1);
        step();
        chk("div0_v", 32'(current_flags[FLAG_V]), 32'd1);
        chk("div0_busy", 32'(busy), 32'd0);
        chk("div0_no_hi", 32'(wb_en), 32'd0);

        // DIV with remainder
        drive(OP_DIV, 3'd6, 3'd1, 3'd2, 16'h0011, 16'h0004, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        $display("div q: wb_en=%0d addr=%0d data=%h", wb_en, wb_addr, wb_data);
        chk("div_q_data", 32'(wb_data), 32'h0004);
        chk("div_q_ready", 32'(issue_ready), 32'd0);
        step();
        $display("div r: wb_en=%0d addr=%0d data=%h", wb_en, wb_addr, wb_data);
        chk("div_r_addr", 32'(wb_addr), 32'd7);
        chk("div_r_data", 32'(wb_data), 32'h0001);
        step();

        // Reset during WB_HI of a MUL, with a simultaneous issue
        drive(OP_MUL, 3'd1, 3'd1, 3'd2, 16'h0002, 16'h0003, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        chk("rst_whi_addr", 32'(wb_addr), 32'd2);
        reset = 1'b1;
        drive(OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0001, 16'h0001, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        reset = 1'b0;
        issue_valid = 1'b0;
        $display("after reset: wb_en=%0d busy=%0d ready=%0d flags=%h", wb_en, busy, issue_ready, current_flags);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_flags", 32'(current_flags), 32'h0);

        // Illegal opcode after reset
        drive(5'd30, 3'd4, 3'd1, 3'd2, 16'h0001, 16'h0002, 8'h00, 4'd0);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        $display("illegal: wb_en=%0d busy=%0d", wb_en, busy);
        chk("ill_wb_en", 32'(wb_en), 32'd0);
        chk("ill_busy", 32'(busy), 32'd1);
        step();
        chk("ill_flags", 32'(current_flags), 32'h0);
        chk("ill_idle_wb", 32'(wb_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
